// File: rtl/periph_arbiter.sv
// ---------------------------------------------------------------------------
// periph_arbiter
//
// Shares a single peripheral send/ack channel between two CPU-side
// requesters. Each side speaks a four-phase send/ack handshake. Grants are
// round-robin, one transaction is in flight at a time, and the granted
// requester's data is latched at the grant so later changes are ignored.
//
// Optional build macro: ARB_TIMEOUT_EN
//   When defined, a wait counter aborts a transaction that has been stuck
//   for TIMEOUT_CYC cycles either waiting for the peripheral ack (REQ) or
//   waiting for the peripheral to release its ack (DONE). An abort raises
//   outErr for one cycle. Without the macro, the arbiter waits forever and
//   outErr is tied low.
//
// Ports:
//   clkARB    in   clock, all logic on the rising edge
//   rstARB    in   synchronous active-high reset
//   inSend0   in   requester 0 send request
//   inData0   in   requester 0 data (DATA_W), stable while inSend0 is high
//   outAck0   out  ack to requester 0
//   inSend1   in   requester 1 send request
//   inData1   in   requester 1 data (DATA_W)
//   outAck1   out  ack to requester 1
//   outSend   out  send to peripheral
//   outData   out  data to peripheral (DATA_W), registered at grant
//   inAck     in   ack from peripheral
//   outGrant  out  index of the current or last granted requester
//   outBusy   out  high whenever the arbiter is not idle
//   outErr    out  one-cycle timeout pulse
// ---------------------------------------------------------------------------
module periph_arbiter #(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clkARB,
    input  logic              rstARB,
    input  logic              inSend0,
    input  logic [DATA_W-1:0] inData0,
    output logic              outAck0,
    input  logic              inSend1,
    input  logic [DATA_W-1:0] inData1,
    output logic              outAck1,
    output logic              outSend,
    output logic [DATA_W-1:0] outData,
    input  logic              inAck,
    output logic              outGrant,
    output logic              outBusy,
    output logic              outErr
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DONE
    } StateT;

    StateT state;
    logic  pointer;
    logic  pickIdx;
    logic  grantedSend;

    // Choose which requester would win if a grant happened this cycle.
    // A lone requester always wins; when both ask, the round-robin pointer
    // decides, so the side that was served last goes second.
    always_comb begin
        pickIdx = pointer;
        if (inSend0 && !inSend1) begin
            pickIdx = 1'b0;
        end else if (inSend1 && !inSend0) begin
            pickIdx = 1'b1;
        end
    end

    // Send level of whichever requester currently owns the channel; the
    // other requester's send is irrelevant until we are back in IDLE.
    assign grantedSend = outGrant ? inSend1 : inSend0;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] waitCnt;
    logic             timedOut;

    // The wait counter starts at zero on entry to REQ or DONE, so the
    // TIMEOUT_CYC-th waiting edge is the one on which the counter already
    // holds TIMEOUT_CYC-1; that edge performs the abort.
    assign timedOut = (waitCnt == CNT_LAST);
`else
    logic [31:0] unusedTimeoutCyc;

    // Without the timeout feature the parameter has no consumer; this
    // keeps it referenced so both builds share one parameter list.
    assign unusedTimeoutCyc = 32'(TIMEOUT_CYC);
    assign outErr           = 1'b0;
`endif

    // Main handshake sequencer. Every output is a register updated here.
    // IDLE grants and latches data, REQ waits for the peripheral ack and
    // forwards it, HOLD waits for the requester to drop send and releases
    // the peripheral, DONE waits for the peripheral to drop ack, clears the
    // requester ack and hands priority to the other side. outData and
    // outGrant are only written on a grant, so they hold until the next one.
    always_ff @(posedge clkARB) begin
        if (rstARB) begin
            state    <= IDLE;
            pointer  <= 1'b0;
            outSend  <= 1'b0;
            outAck0  <= 1'b0;
            outAck1  <= 1'b0;
            outData  <= '0;
            outGrant <= 1'b0;
            outBusy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            waitCnt  <= '0;
            outErr   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            outErr <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (inSend0 || inSend1) begin
                        outData  <= pickIdx ? inData1 : inData0;
                        outGrant <= pickIdx;
                        outSend  <= 1'b1;
                        outBusy  <= 1'b1;
                        state    <= REQ;
`ifdef ARB_TIMEOUT_EN
                        waitCnt  <= '0;
`endif
                    end
                end

                REQ: begin
                    if (inAck) begin
                        if (outGrant) begin
                            outAck1 <= 1'b1;
                        end else begin
                            outAck0 <= 1'b1;
                        end
                        state <= HOLD;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (timedOut) begin
                        outSend <= 1'b0;
                        outErr  <= 1'b1;
                        outBusy <= 1'b0;
                        pointer <= ~outGrant;
                        state   <= IDLE;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
`endif
                end

                HOLD: begin
                    if (!grantedSend) begin
                        outSend <= 1'b0;
                        state   <= DONE;
`ifdef ARB_TIMEOUT_EN
                        waitCnt <= '0;
`endif
                    end
                end

                DONE: begin
                    if (!inAck) begin
                        outAck0 <= 1'b0;
                        outAck1 <= 1'b0;
                        outBusy <= 1'b0;
                        pointer <= ~outGrant;
                        state   <= IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (timedOut) begin
                        outAck0 <= 1'b0;
                        outAck1 <= 1'b0;
                        outErr  <= 1'b1;
                        outBusy <= 1'b0;
                        pointer <= ~outGrant;
                        state   <= IDLE;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_arbiter.sv
// ---------------------------------------------------------------------------
// tb_periph_arbiter
//
// Drives periph_arbiter with behavioural requesters and a behavioural
// peripheral. Each table record describes one burst of requests; the bench
// predicts the grant order, latched data and send-pulse length and queues
// them, then checks each peripheral transaction as it appears.
// ---------------------------------------------------------------------------
module tb_periph_arbiter;

    localparam int DATA_W      = 16;
    localparam int TIMEOUT_CYC = 8;
    localparam int NUM_VECS    = 9;

    logic              clkARB;
    logic              rstARB;
    logic              inSend0;
    logic [DATA_W-1:0] inData0;
    logic              outAck0;
    logic              inSend1;
    logic [DATA_W-1:0] inData1;
    logic              outAck1;
    logic              outSend;
    logic [DATA_W-1:0] outData;
    logic              inAck;
    logic              outGrant;
    logic              outBusy;
    logic              outErr;

    periph_arbiter #(
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clkARB   (clkARB),
        .rstARB   (rstARB),
        .inSend0  (inSend0),
        .inData0  (inData0),
        .outAck0  (outAck0),
        .inSend1  (inSend1),
        .inData1  (inData1),
        .outAck1  (outAck1),
        .outSend  (outSend),
        .outData  (outData),
        .inAck    (inAck),
        .outGrant (outGrant),
        .outBusy  (outBusy),
        .outErr   (outErr)
    );

    typedef struct {
        bit                s0;
        bit                s1;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        int                ackDelay;
        int                holdExtra;
        bit                scramble;
    } VecT;

    typedef struct {
        bit                grant;
        logic [DATA_W-1:0] data;
        int                len;
        bit                expErr;
    } ExpT;

    ExpT sbQ[$];
    ExpT cur;
    VecT vecs[NUM_VECS];
    VecT tmpVec;

    bit curValid;
    bit ptrModel;
    bit prevSend;
    bit monitorOff;
    bit periphMute;
    bit scrambleArmed;
    int ackDelay;
    int holdExtra;
    int ackCnt;
    int holdCnt0;
    int holdCnt1;
    int sendRun;
    int errSeen;
    int vectors;
    int miscompares;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clkARB = 1'b0;
        forever #5 clkARB = ~clkARB;
    end

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // Expected record for requester g taking part in vector v.
    function automatic ExpT expFor(input bit g, input VecT v);
        ExpT e;
        e.grant  = g;
        e.data   = g ? v.d1 : v.d0;
        e.len    = 2 + v.ackDelay + v.holdExtra;
        e.expErr = 1'b0;
        return e;
    endfunction

    // Load a table record onto the requesters and queue the predicted
    // transactions. With both requesting, the pointer side goes first and
    // the pointer ends where it started; a single requester N leaves the
    // pointer at ~N.
    task automatic applyStimulus(input VecT v);
        bit first;
        inData0       = v.d0;
        inData1       = v.d1;
        ackDelay      = v.ackDelay;
        holdExtra     = v.holdExtra;
        scrambleArmed = v.scramble;
        if (v.s0 && v.s1) begin
            first = ptrModel;
            sbQ.push_back(expFor(first, v));
            sbQ.push_back(expFor(~first, v));
        end else if (v.s0) begin
            sbQ.push_back(expFor(1'b0, v));
            ptrModel = 1'b1;
        end else if (v.s1) begin
            sbQ.push_back(expFor(1'b1, v));
            ptrModel = 1'b0;
        end
        inSend0 = v.s0;
        inSend1 = v.s1;
    endtask

    // One clock: at the falling edge, check what the DUT did on the last
    // rising edge, then let the requester and peripheral models react.
    task automatic tick();
        @(negedge clkARB);
        if (!monitorOff) begin
            checkOutput("ackExclusive", {31'b0, outAck0 & outAck1}, 32'd0);
            if (outSend && !prevSend) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedGrant", {31'b0, outSend}, 32'd0);
                end else begin
                    cur      = sbQ.pop_front();
                    curValid = 1'b1;
                    checkOutput("grantIdx", {31'b0, outGrant}, {31'b0, cur.grant});
                    checkOutput("grantData", {16'b0, outData}, {16'b0, cur.data});
                    checkOutput("busyOnGrant", {31'b0, outBusy}, 32'd1);
                    sendRun = 1;
                    if (scrambleArmed) begin
                        inData0       = 16'hFFFF;
                        inData1       = 16'hFFFF;
                        scrambleArmed = 1'b0;
                    end
                end
            end else if (outSend) begin
                sendRun++;
            end else if (prevSend && curValid) begin
                checkOutput("sendLen", sendRun, cur.len);
                checkOutput("holdData", {16'b0, outData}, {16'b0, cur.data});
                checkOutput("errAtRelease", {31'b0, outErr}, {31'b0, cur.expErr});
            end
            if (curValid && outBusy) begin
                checkOutput("otherAck", {31'b0, cur.grant ? outAck0 : outAck1}, 32'd0);
            end
            if (outErr) begin
                errSeen++;
                periphMute = 1'b0;
            end
            prevSend = outSend;

            if (!periphMute) begin
                if (outSend && !inAck) begin
                    if (ackCnt >= ackDelay) begin
                        inAck  = 1'b1;
                        ackCnt = 0;
                    end else begin
                        ackCnt++;
                    end
                end else if (!outSend && inAck) begin
                    inAck = 1'b0;
                end
            end
            if (inSend0 && outAck0) begin
                if (holdCnt0 >= holdExtra) begin
                    inSend0  = 1'b0;
                    holdCnt0 = 0;
                end else begin
                    holdCnt0++;
                end
            end
            if (inSend1 && outAck1) begin
                if (holdCnt1 >= holdExtra) begin
                    inSend1  = 1'b0;
                    holdCnt1 = 0;
                end else begin
                    holdCnt1++;
                end
            end
        end
    endtask

    // Run until every requester is satisfied and the arbiter is idle, with
    // a cycle budget so a stuck DUT still reaches the summary.
    task automatic serve();
        int budget;
        budget = 400;
        while ((inSend0 || inSend1 || inAck || outBusy) && budget > 0) begin
            tick();
            budget--;
        end
    endtask

    // Post-burst checks: quiet channel, nothing left predicted, and the
    // last grant's data and index still held.
    task automatic checkIdle();
        checkOutput("serveDone", {31'b0, outBusy | inSend0 | inSend1 | inAck}, 32'd0);
        checkOutput("sbEmpty", sbQ.size(), 32'd0);
        checkOutput("idleSend", {31'b0, outSend}, 32'd0);
        checkOutput("idleAcks", {30'b0, outAck0, outAck1}, 32'd0);
        if (curValid) begin
            checkOutput("dataHeld", {16'b0, outData}, {16'b0, cur.data});
            checkOutput("grantHeld", {31'b0, outGrant}, {31'b0, cur.grant});
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Send"}, {31'b0, outSend}, 32'd0);
        checkOutput({tag, "Acks"}, {30'b0, outAck0, outAck1}, 32'd0);
        checkOutput({tag, "Data"}, {16'b0, outData}, 32'd0);
        checkOutput({tag, "Grant"}, {31'b0, outGrant}, 32'd0);
        checkOutput({tag, "Busy"}, {31'b0, outBusy}, 32'd0);
        checkOutput({tag, "Err"}, {31'b0, outErr}, 32'd0);
    endtask

    initial begin
        bit g;
        int budget;

        vectors       = 0;
        miscompares   = 0;
        curValid      = 1'b0;
        ptrModel      = 1'b0;
        prevSend      = 1'b0;
        periphMute    = 1'b0;
        scrambleArmed = 1'b0;
        ackDelay      = 0;
        holdExtra     = 0;
        ackCnt        = 0;
        holdCnt0      = 0;
        holdCnt1      = 0;
        sendRun       = 0;
        errSeen       = 0;
        inSend0       = 1'b0;
        inSend1       = 1'b0;
        inData0       = '0;
        inData1       = '0;
        inAck         = 1'b0;
        rstARB        = 1'b1;
        monitorOff    = 1'b1;

        //           s0    s1    d0        d1        ackD hold scr
        vecs[0] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 0,   0,   1'b0};
        vecs[1] = '{1'b1, 1'b1, 16'h3333, 16'h4444, 0,   0,   1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h00A5, 16'h0000, 0,   0,   1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'h0101, 16'h0202, 1,   0,   1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'h0003, 0,   0,   1'b1};
        vecs[5] = '{1'b1, 1'b1, 16'h5555, 16'h6666, 0,   10,  1'b0};
        vecs[6] = '{1'b1, 1'b1, 16'h7777, 16'h8888, 3,   2,   1'b0};
        vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'hABCD, 5,   1,   1'b0};
        vecs[8] = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 0,   0,   1'b0};

        repeat (2) tick();
        checkAllZero("reset");
        rstARB     = 1'b0;
        monitorOff = 1'b0;

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            serve();
            checkIdle();
            tick();
        end

        // Reset in the middle of a transaction. First leave the pointer at
        // 1, then reset while requester 0 is parked in HOLD; afterwards a
        // simultaneous request must go to requester 0 first.
        tmpVec = '{1'b1, 1'b0, 16'h1234, 16'h0000, 0, 0, 1'b0};
        applyStimulus(tmpVec);
        serve();
        checkIdle();
        tmpVec = '{1'b1, 1'b0, 16'hBEEF, 16'h0000, 0, 20, 1'b0};
        applyStimulus(tmpVec);
        budget = 20;
        while (!outAck0 && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput("reachHold", {31'b0, outAck0}, 32'd1);
        monitorOff = 1'b1;
        rstARB     = 1'b1;
        tick();
        checkAllZero("midReset");
        rstARB   = 1'b0;
        inSend0  = 1'b0;
        inSend1  = 1'b0;
        inAck    = 1'b0;
        ackCnt   = 0;
        holdCnt0 = 0;
        holdCnt1 = 0;
        sbQ.delete();
        curValid = 1'b0;
        prevSend = 1'b0;
        ptrModel = 1'b0;
        tick();
        checkOutput("noAckAfterReset", {30'b0, outAck0, outAck1}, 32'd0);
        checkOutput("idleAfterReset", {31'b0, outBusy}, 32'd0);
        monitorOff = 1'b0;
        tmpVec = '{1'b1, 1'b1, 16'h9999, 16'hAAAA, 0, 0, 1'b0};
        applyStimulus(tmpVec);
        serve();
        checkIdle();
        tick();

`ifdef ARB_TIMEOUT_EN
        // Peripheral silent: the first grant aborts after TIMEOUT_CYC
        // cycles with one error pulse, the other requester is served next,
        // and the aborted requester (still sending) is served after that.
        tmpVec = '{1'b1, 1'b1, 16'h0BAD, 16'h0C0D, 0, 0, 1'b0};
        g = ptrModel;
        cur = expFor(g, tmpVec);
        cur.len    = TIMEOUT_CYC;
        cur.expErr = 1'b1;
        sbQ.push_back(cur);
        sbQ.push_back(expFor(~g, tmpVec));
        sbQ.push_back(expFor(g, tmpVec));
        ptrModel   = ~g;
        errSeen    = 0;
        periphMute = 1'b1;
        inData0    = tmpVec.d0;
        inData1    = tmpVec.d1;
        ackDelay   = 0;
        holdExtra  = 0;
        inSend0    = 1'b1;
        inSend1    = 1'b1;
        serve();
        checkOutput("errPulses", errSeen, 32'd1);
        checkIdle();
`else
        g = 1'b0;
        checkOutput("errNeverSeen", errSeen + {31'b0, g}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
